add_sched: RTL and testbench
============================

Name: add_sched

Overview:
- Round-robin scheduler that shares one two-cycle-latency W-bit adder among N_REQ requesters.
- Accepts operand pairs over a valid/ready handshake and drives the adder's start/a/b inputs.
- Holds operands for the adder's two-phase operand capture: a is sampled at issue, b one cycle later.
- Returns each sum with the requester ID. Sits between client blocks and the shared adder instance.

Parameters:
- W, 10, operand/result width; matches the adder's W.
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), requester ID width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = arbitration allowed; 0 = no new grants, in-flight op completes
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_a  in  N_REQ*W  packed operand a; requester i at [i*W +: W]
- req_b  in  N_REQ*W  packed operand b
- add_start  out  1  adder start pulse
- add_a  out  W  adder operand a
- add_b  out  W  adder operand b
- add_y  in  W  adder sum
- add_valid  in  1  adder result valid
- rsp_valid  out  1  response pulse; no backpressure
- rsp_id  out  ID_W  requester ID of the response
- rsp_y  out  W  sum, modulo 2^W
- err_unexp  out  1  sticky: add_valid seen with no op in flight
- stat_issue_cnt  out  16  see Optional Feature
- stat_stall_cnt  out  16  see Optional Feature

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer 0, tag pipeline empty.
- Reset is asynchronous at any time. It drops any in-flight op; no rsp_valid is produced for it. The adder shares rst_n.
- FSM states:
  - IDLE: add_start=0.
  - ISSUE: add_start=1; add_a/add_b carry the granted operands.
  - HOLD: add_start=0; add_a/add_b unchanged from ISSUE.
- Grant condition: enable=1 and at least one req_valid, evaluated in IDLE or HOLD.
- Transitions:
  - IDLE goes to ISSUE on grant, else stays IDLE.
  - ISSUE always goes to HOLD.
  - HOLD goes to ISSUE on grant, else IDLE.
- No grant is ever made in ISSUE.
- Grant timing:
  - req_ready is combinational, asserted for the winner only in the grant cycle c. The transfer completes at the clock edge ending c.
  - The winner's operands and ID are registered and appear at add_a/add_b/add_start in cycle c+1 (ISSUE).
- Arbitration: round-robin starting at the pointer. After a grant to i, the pointer becomes (i+1) mod N_REQ. With no grant, the pointer is unchanged.
- In IDLE, add_a/add_b keep their last values.
- Throughput and latency:
  - At most one issue per 2 cycles.
  - add_valid is expected in cycle c+3.
  - rsp_valid/rsp_id/rsp_y are registered from add_valid/add_y and are valid in cycle c+4.
  - Handshake to response latency is 4 cycles.
  - Back-to-back grants in c and c+2 give responses in c+4 and c+6.
- Tag tracking: a 2-stage ID/valid shift register is loaded at ISSUE and consumed when add_valid=1 two cycles later.
  - If add_valid=1 with stage-2 valid=0, set err_unexp (cleared only by reset) and produce no rsp_valid.
  - If stage-2 valid=1 and add_valid=0, no response is produced and the tag is dropped.
- enable dropping in HOLD or ISSUE does not cancel the op; only new grants stop.
- Arithmetic: rsp_y = add_y unchanged; the sum wraps mod 2^W.
- req_valid dropping without ready: no state is affected.

Optional Feature:
- Macro: ADD_SCHED_STATS_EN.
- Defined:
  - stat_issue_cnt increments on every ISSUE cycle.
  - stat_stall_cnt increments on every cycle where any req_valid=1 and no req_ready is asserted.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Single op: req_valid[2]=1, a=100, b=23 in cycle 0. Expect req_ready=4'b0100 in cycle 0; add_start=1, add_a=100, add_b=23 in cycle 1; add_b=23 still held in cycle 2; rsp_valid=1, rsp_id=2, rsp_y=123 in cycle 4.
- Fairness: all four req_valid held high with distinct operands. Expect grants in cycles 0,2,4,6,8 to IDs 0,1,2,3,0; responses in cycles 4,6,8,10,12 in the same ID order with correct sums.
- Wrap: a=1000, b=100 on requester 1. Expect rsp_y=76, rsp_id=1.
- enable=0 with req_valid[3]=1 for 5 cycles. Expect no req_ready and add_start=0; with stats enabled, stat_stall_cnt=5. Raise enable: grant to 3 in the same cycle.
- Reset mid-op: assert rst_n=0 in the HOLD cycle. Expect all outputs 0 immediately, no rsp_valid afterward, and next grant after reset goes to requester 0.
- Spurious add_valid forced high with no op issued. Expect err_unexp=1 from the next cycle, held; rsp_valid stays 0.

Source files
------------

// File: rtl/add_sched.sv
// add_sched: round-robin scheduler sharing one two-cycle-latency adder among
// N_REQ requesters. Operand a is presented with add_start, b is held one more
// cycle, and each sum returns tagged with the requester ID.
// Optional statistics counters are enabled by defining ADD_SCHED_STATS_EN.
module add_sched #(
  parameter int W     = 10,
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  output logic                 add_start,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  input  logic [W-1:0]         add_y,
  input  logic                 add_valid,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [W-1:0]         rsp_y,
  output logic                 err_unexp,
  output logic [15:0]          stat_issue_cnt,
  output logic [15:0]          stat_stall_cnt
);

  localparam int unsigned NR = N_REQ;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win_id;
  logic            found;
  logic            grant;
  logic [ID_W-1:0] issue_id;
  logic            s1_v, s2_v;
  logic [ID_W-1:0] s1_id, s2_id;

  // Round-robin search for the first valid requester starting at the pointer
  always_comb begin
    int unsigned idx;
    win_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (32'(ptr) + k) % NR;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        win_id = ID_W'(idx);
      end
    end
  end

  assign grant     = enable && found && (state == S_IDLE || state == S_HOLD);
  assign req_ready = grant ? (N_REQ'(1) << win_id) : '0;
  assign add_start = (state == S_ISSUE);

  // Next-state logic: a grant in IDLE or HOLD always leads to ISSUE
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = grant ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nxt = S_HOLD;
      S_HOLD:  state_nxt = grant ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM, pointer and operand capture; operands stay put until the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      add_a    <= '0;
      add_b    <= '0;
      issue_id <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        add_a    <= req_a[win_id*W +: W];
        add_b    <= req_b[win_id*W +: W];
        issue_id <= win_id;
        ptr      <= (32'(win_id) == NR - 1) ? '0 : win_id + 1'b1;
      end
    end
  end

  // Two-stage tag pipeline aligned with the adder latency, plus response regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_id     <= '0;
      s2_v      <= 1'b0;
      s2_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      err_unexp <= 1'b0;
    end else begin
      s1_v      <= (state == S_ISSUE);
      s1_id     <= issue_id;
      s2_v      <= s1_v;
      s2_id     <= s1_id;
      rsp_valid <= add_valid && s2_v;
      if (add_valid && s2_v) begin
        rsp_id <= s2_id;
        rsp_y  <= add_y;
      end
      if (add_valid && !s2_v)
        err_unexp <= 1'b1;
    end
  end

`ifdef ADD_SCHED_STATS_EN
  // Saturating issue and stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issue_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (state == S_ISSUE && stat_issue_cnt != 16'hFFFF)
        stat_issue_cnt <= stat_issue_cnt + 16'd1;
      if ((|req_valid) && !(|req_ready) && stat_stall_cnt != 16'hFFFF)
        stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`else
  assign stat_issue_cnt = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_add_sched.sv
// Scoreboard bench for add_sched with a behavioural two-cycle adder model.
module tb_add_sched;
  localparam int W = 10;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           add_start;
  logic [W-1:0]   add_a, add_b, add_y;
  logic           add_valid;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_y;
  logic           err_unexp;
  logic [15:0]    stat_issue_cnt, stat_stall_cnt;

  add_sched #(.W(W), .N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_y(add_y), .add_valid(add_valid),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .err_unexp(err_unexp),
    .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder model: a captured with start, b one cycle later, sum valid next cycle
  logic         p1, mv, force_v;
  logic [W-1:0] a_q, my;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= 1'b0; mv <= 1'b0; a_q <= '0; my <= '0;
    end else begin
      p1 <= add_start;
      if (add_start) a_q <= add_a;
      mv <= p1;
      if (p1) my <= a_q + add_b;
    end
  end
  assign add_valid = mv | force_v;
  assign add_y     = my;

  typedef struct { int cyc; int id; int y; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest expected entry
  always @(negedge clk) begin
    if (rsp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected actual id=%0d y=%0d cycle=%0d required none", rsp_id, rsp_y, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (int'(rsp_id) != e.id || int'(rsp_y) != e.y || cyc != e.cyc) begin
          failures++;
          $display("FAIL rsp actual id=%0d y=%0d cycle=%0d required id=%0d y=%0d cycle=%0d",
                   rsp_id, rsp_y, cyc, e.id, e.y, e.cyc);
        end
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_start"}, 32'(add_start), 0);
    check({tag, "_adda"},  32'(add_a), 0);
    check({tag, "_addb"},  32'(add_b), 0);
    check({tag, "_rspv"},  32'(rsp_valid), 0);
    check({tag, "_rspid"}, 32'(rsp_id), 0);
    check({tag, "_rspy"},  32'(rsp_y), 0);
    check({tag, "_err"},   32'(err_unexp), 0);
    check({tag, "_issue"}, 32'(stat_issue_cnt), 0);
    check({tag, "_stall"}, 32'(stat_stall_cnt), 0);
  endtask

  int fa[4] = '{100, 150, 200, 250};
  int fb[4] = '{7, 8, 9, 10};
  int fs[4] = '{107, 158, 209, 260};

  initial begin
    rst_n = 1'b0; enable = 1'b1; req_valid = '0; req_a = '0; req_b = '0; force_v = 1'b0;

    // Reset state
    smp();
    check_all_zero("reset");
    step(); step();
    rst_n = 1'b1;
    step();

    // enable=0 for 5 cycles with requester 3 waiting, then grant on raise
    enable = 1'b0; req_valid = 4'b1000; set_op(3, 5, 6);
    for (int k = 0; k < 5; k++) begin
      smp();
      check("dis_ready", 32'(req_ready), 0);
      check("dis_start", 32'(add_start), 0);
      step();
    end
    enable = 1'b1;
    smp();
    check("en_ready", 32'(req_ready), 32'b1000);
`ifdef ADD_SCHED_STATS_EN
    check("stall_cnt", 32'(stat_stall_cnt), 5);
`else
    check("stall_tied", 32'(stat_stall_cnt), 0);
`endif
    sb.push_back('{cyc + 4, 3, 11});
    step(); req_valid = '0;
    smp();
    check("en_start", 32'(add_start), 1);
    check("en_adda", 32'(add_a), 5);
    check("en_addb", 32'(add_b), 6);
    step();
    smp();
    check("en_hold_start", 32'(add_start), 0);
    check("en_hold_b", 32'(add_b), 6);
    repeat (4) step();
`ifdef ADD_SCHED_STATS_EN
    check("issue_cnt", 32'(stat_issue_cnt), 1);
`else
    check("issue_tied", 32'(stat_issue_cnt), 0);
`endif

    // Fairness: all four requesting; grants every other cycle 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_op(i, fa[i], fb[i]);
    req_valid = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      int id;
      id = (k / 2) % 4;
      smp();
      if (k % 2 == 0) begin
        check("fair_ready", 32'(req_ready), 32'(1) << id);
        sb.push_back('{cyc + 4, id, fs[id]});
      end else begin
        check("fair_idle", 32'(req_ready), 0);
      end
      step();
    end
    req_valid = '0;
    repeat (8) step();

    // Single op on requester 2
    set_op(2, 100, 23); req_valid = 4'b0100;
    smp();
    check("single_ready", 32'(req_ready), 32'b0100);
    sb.push_back('{cyc + 4, 2, 123});
    step(); req_valid = '0;
    smp();
    check("single_start", 32'(add_start), 1);
    check("single_adda", 32'(add_a), 100);
    check("single_addb", 32'(add_b), 23);
    step();
    smp();
    check("single_hold_b", 32'(add_b), 23);
    check("single_hold_start", 32'(add_start), 0);
    repeat (5) step();

    // Wrap: 1000 + 100 = 1100 mod 1024 = 76
    set_op(1, 1000, 100); req_valid = 4'b0010;
    smp();
    check("wrap_ready", 32'(req_ready), 32'b0010);
    sb.push_back('{cyc + 4, 1, 76});
    step(); req_valid = '0;
    repeat (6) step();

    // Reset in HOLD: op dropped, pointer back to 0
    set_op(1, 300, 200); req_valid = 4'b0010;
    smp();
    check("rst_op_ready", 32'(req_ready), 32'b0010);
    step(); req_valid = '0;
    step();
    rst_n = 1'b0;
    smp();
    check_all_zero("midrst");
    step();
    rst_n = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 4; i++) set_op(i, fa[i], fb[i]);
    req_valid = 4'b1111;
    smp();
    check("post_rst_ready", 32'(req_ready), 32'b0001);
    sb.push_back('{cyc + 4, 0, 107});
    step(); req_valid = '0;
    repeat (6) step();

    // Spurious add_valid with nothing in flight
    force_v = 1'b1;
    smp();
    check("spur_err_before", 32'(err_unexp), 0);
    step(); force_v = 1'b0;
    smp();
    check("spur_err_set", 32'(err_unexp), 1);
    step(); step();
    smp();
    check("spur_err_held", 32'(err_unexp), 1);
    check("spur_rspv", 32'(rsp_valid), 0);

    // Drain: all expected responses must have appeared
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    check("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
